// File: rtl/adc_scan_pkg.sv
// Shared constants, state encoding and helpers for the ADC scan sequencer.
package adc_scan_pkg;

  // Output word layout: {sof, ch[2:0], sample[11:0]}
  localparam int WORD_W   = 16;
  localparam int SOF_BIT  = 15;
  localparam int CH_MSB   = 14;
  localparam int CH_LSB   = 12;
  localparam int DATA_MSB = 11;

  // Shortest usable scan period; smaller programmed values are clamped to this
  localparam int MIN_PERIOD = 2;

  // FSM state encoding
  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_WAIT_TICK = 3'd1;
  localparam logic [2:0] ST_SEEK      = 3'd2;
  localparam logic [2:0] ST_START     = 3'd3;
  localparam logic [2:0] ST_WAIT_DONE = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE      = ST_IDLE,
    S_WAIT_TICK = ST_WAIT_TICK,
    S_SEEK      = ST_SEEK,
    S_START     = ST_START,
    S_WAIT_DONE = ST_WAIT_DONE
  } state_t;

  // Lowest enabled channel at or above cursor. Result bit 3 = found,
  // bits 2:0 = channel. A cursor of 8 (scan wrapped) never finds anything.
  function automatic logic [3:0] find_next(input logic [7:0] mask, input logic [3:0] cursor);
    logic [3:0] res;
    res = 4'd0;
    for (int i = 7; i >= 0; i--) begin
      if (mask[i] && (4'(i) >= cursor)) begin
        res = {1'b1, 3'(i)};
      end
    end
    return res;
  endfunction

  // Assemble a result word from its fields
  function automatic logic [WORD_W-1:0] pack_word(input logic sof, input logic [2:0] ch,
                                                  input logic [DATA_MSB:0] sample);
    logic [WORD_W-1:0] w;
    w                 = '0;
    w[SOF_BIT]        = sof;
    w[CH_MSB:CH_LSB]  = ch;
    w[DATA_MSB:0]     = sample;
    return w;
  endfunction

endpackage

// File: rtl/scan_fifo.sv
// First-word-fall-through FIFO for tagged ADC result words. The head word is
// read combinationally so a push into an empty FIFO is visible next cycle.
// A push while full is accepted only if a pop happens in the same cycle.
module scan_fifo
  import adc_scan_pkg::*;
#(
  parameter int WIDTH = WORD_W,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_pop_ok;
  logic             w_push_ok;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CNT_FULL);
  assign w_pop_ok  = i_pop && !o_empty;
  assign w_push_ok = i_push && (!o_full || w_pop_ok);

  // Storage array, written on accepted pushes only
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Head word; forced to zero when empty so the output is clean after reset
  assign o_data = o_empty ? '0 : r_mem[r_rd_ptr];

endmodule

// File: rtl/adc_scan_sequencer.sv
// Periodic channel scanner in front of the adc128s022 controller. Paces scans
// over a latched channel mask, issues one conversion per enabled channel,
// tags each result with channel and start-of-scan, and queues it in a FWFT FIFO.
module adc_scan_sequencer
  import adc_scan_pkg::*;
#(
  parameter int FIFO_DEPTH   = 16,
  parameter int PERIOD_W     = 24,
  parameter int DONE_TIMEOUT = 1024
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_en,
  input  logic [7:0]          i_ch_mask,
  input  logic [PERIOD_W-1:0] i_scan_period,
  input  logic                i_clr,
  output logic                o_cv_go,
  output logic [2:0]          o_chx,
  input  logic                i_adc_done,
  input  logic [11:0]         i_adc_data,
  output logic [15:0]         o_out_data,
  output logic                o_out_valid,
  input  logic                i_out_ready,
  output logic                o_err_ovf,
  output logic                o_err_late,
  output logic                o_err_tmo
);

  localparam int TMO_W = (DONE_TIMEOUT > 2) ? $clog2(DONE_TIMEOUT) : 1;
  localparam logic [TMO_W-1:0]    TMO_LAST = TMO_W'(DONE_TIMEOUT - 1);
  localparam logic [TMO_W-1:0]    TMO_ONE  = TMO_W'(1);
  localparam logic [PERIOD_W-1:0] P_MIN    = PERIOD_W'(MIN_PERIOD);
  localparam logic [PERIOD_W-1:0] P_ONE    = PERIOD_W'(1);

  state_t              r_state;
  state_t              w_state_next;
  logic [PERIOD_W-1:0] r_timer;
  logic [PERIOD_W-1:0] w_period;
  logic                w_tick;
  logic [7:0]          r_mask;
  logic [3:0]          r_cursor;
  logic [2:0]          r_chx;
  logic                r_sof_pend;
  logic [TMO_W-1:0]    r_tmo_cnt;
  logic [3:0]          w_seek;
  logic                w_found;
  logic                w_tmo_hit;
  logic                w_push;
  logic                w_tmo_fire;
  logic                w_scan_start;
  logic                w_pop;
  logic                w_full;
  logic                w_empty;
  logic [15:0]         w_push_word;
  logic                r_err_ovf;
  logic                r_err_late;
  logic                r_err_tmo;

  // Effective period with the lower clamp applied
  assign w_period = (i_scan_period < P_MIN) ? P_MIN : i_scan_period;
  assign w_tick   = i_en && (r_timer >= (w_period - P_ONE));

  // Free-running period timer, held at zero while disabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_timer <= '0;
    end else if (!i_en || w_tick) begin
      r_timer <= '0;
    end else begin
      r_timer <= r_timer + P_ONE;
    end
  end

  assign w_seek    = find_next(r_mask, r_cursor);
  assign w_found   = w_seek[3];
  assign w_tmo_hit = (r_tmo_cnt == TMO_LAST);

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next-state and per-state strobes
  always_comb begin
    w_state_next = r_state;
    w_push       = 1'b0;
    w_tmo_fire   = 1'b0;
    w_scan_start = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_en) begin
          w_state_next = S_WAIT_TICK;
        end
      end
      S_WAIT_TICK: begin
        if (!i_en) begin
          w_state_next = S_IDLE;
        end else if (w_tick) begin
          w_state_next = S_SEEK;
          w_scan_start = 1'b1;
        end
      end
      S_SEEK: begin
        // Dropping en ends the scan here; the in-flight result was already taken
        if (!i_en) begin
          w_state_next = S_IDLE;
        end else if (w_found) begin
          w_state_next = S_START;
        end else begin
          w_state_next = S_WAIT_TICK;
        end
      end
      S_START: begin
        w_state_next = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        // A result on the last allowed cycle still wins over the timeout
        if (i_adc_done) begin
          w_push       = 1'b1;
          w_state_next = S_SEEK;
        end else if (w_tmo_hit) begin
          w_tmo_fire   = 1'b1;
          w_state_next = S_SEEK;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Scan context: latched mask, cursor, selected channel, sof marker, timeout count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mask     <= '0;
      r_cursor   <= '0;
      r_chx      <= '0;
      r_sof_pend <= 1'b0;
      r_tmo_cnt  <= '0;
    end else begin
      if (w_scan_start) begin
        r_mask     <= i_ch_mask;
        r_cursor   <= '0;
        r_sof_pend <= 1'b1;
      end
      if ((r_state == S_SEEK) && i_en && w_found) begin
        r_chx <= w_seek[2:0];
      end
      if (r_state == S_START) begin
        r_tmo_cnt <= '0;
      end else if (r_state == S_WAIT_DONE) begin
        r_tmo_cnt <= r_tmo_cnt + TMO_ONE;
      end
      if (w_push) begin
        r_sof_pend <= 1'b0;
      end
      // Cursor value 8 means the scan has wrapped and SEEK will find nothing
      if (w_push || w_tmo_fire) begin
        r_cursor <= {1'b0, r_chx} + 4'd1;
      end
    end
  end

  assign w_push_word = pack_word(r_sof_pend, r_chx, i_adc_data);
  assign w_pop       = !w_empty && i_out_ready;

  // Sticky error flags; a set in the same cycle as clr wins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_ovf  <= 1'b0;
      r_err_late <= 1'b0;
      r_err_tmo  <= 1'b0;
    end else begin
      if (w_push && w_full && !w_pop) begin
        r_err_ovf <= 1'b1;
      end else if (i_clr) begin
        r_err_ovf <= 1'b0;
      end
      if (w_tick && (r_state != S_WAIT_TICK)) begin
        r_err_late <= 1'b1;
      end else if (i_clr) begin
        r_err_late <= 1'b0;
      end
      if (w_tmo_fire) begin
        r_err_tmo <= 1'b1;
      end else if (i_clr) begin
        r_err_tmo <= 1'b0;
      end
    end
  end

  scan_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (w_push),
    .i_push_data (w_push_word),
    .i_pop       (i_out_ready),
    .o_data      (o_out_data),
    .o_full      (w_full),
    .o_empty     (w_empty)
  );

  assign o_cv_go     = (r_state == S_START);
  assign o_chx       = r_chx;
  assign o_out_valid = !w_empty;
  assign o_err_ovf   = r_err_ovf;
  assign o_err_late  = r_err_late;
  assign o_err_tmo   = r_err_tmo;

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// Randomized bench for adc_scan_sequencer with an ADC responder, a consumer
// and a scan-level model: each scan visits the enabled channels in ascending
// order, the first answered channel carries sof, and a full FIFO drops words.
module tb_adc_scan_sequencer;

  localparam int DEPTH = 16;
  localparam int PW    = 24;
  localparam int TMO   = 1024;

  logic          clk;
  logic          rst_n;
  logic          i_en;
  logic [7:0]    i_ch_mask;
  logic [PW-1:0] i_scan_period;
  logic          i_clr;
  logic          o_cv_go;
  logic [2:0]    o_chx;
  logic          i_adc_done;
  logic [11:0]   i_adc_data;
  logic [15:0]   o_out_data;
  logic          o_out_valid;
  logic          i_out_ready;
  logic          o_err_ovf;
  logic          o_err_late;
  logic          o_err_tmo;

  adc_scan_sequencer #(
    .FIFO_DEPTH   (DEPTH),
    .PERIOD_W     (PW),
    .DONE_TIMEOUT (TMO)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_en          (i_en),
    .i_ch_mask     (i_ch_mask),
    .i_scan_period (i_scan_period),
    .i_clr         (i_clr),
    .o_cv_go       (o_cv_go),
    .o_chx         (o_chx),
    .i_adc_done    (i_adc_done),
    .i_adc_data    (i_adc_data),
    .o_out_data    (o_out_data),
    .o_out_valid   (o_out_valid),
    .i_out_ready   (i_out_ready),
    .o_err_ovf     (o_err_ovf),
    .o_err_late    (o_err_late),
    .o_err_tmo     (o_err_tmo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Model and scenario state
  logic [7:0]  mask_m;
  int          ch_list[$];
  logic [15:0] exp_q[$];
  bit          sof_m;
  bit          exp_ovf, exp_tmo, late_exp_ph;
  int          lat, dead_ch, rdy_mode, rsp_cnt, cur_ch, cur_p, cvgo_cnt;
  bit          fixed_data, exact_p, tmo_chk_done;
  longint      cyc, last_start, dead_cyc, done_cyc;
  logic [11:0] d;

  function automatic bit late_expected(input logic [7:0] m, input int l, input int dead, input int p);
    int cost;
    cost = 2;
    for (int c = 0; c < 8; c++) begin
      if (m[c]) cost += (c == dead) ? (TMO + 2) : (l + 2);
    end
    return cost > p;
  endfunction

  // Driver: consumer, ADC responder and scan model, all acting on the falling edge
  initial begin
    cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        i_adc_done = 1'b0;
      end else begin
        if (cyc == done_cyc + 1 && exp_q.size() > 0) check_val("fwft_valid", o_out_valid, 1);
        // consumer
        case (rdy_mode)
          0:       i_out_ready = 1'b0;
          1:       i_out_ready = 1'b1;
          default: i_out_ready = 1'($urandom_range(0, 1));
        endcase
        if (i_out_ready && o_out_valid) begin
          if (exp_q.size() == 0) check_val("fifo_extra", o_out_valid, 0);
          else check_val("word", o_out_data, exp_q.pop_front());
        end
        // responder
        i_adc_done = 1'b0;
        if (rsp_cnt > 0) begin
          rsp_cnt--;
          if (rsp_cnt == 0) begin
            d = fixed_data ? 12'hA5C : 12'($urandom);
            i_adc_data = d;
            i_adc_done = 1'b1;
            done_cyc   = cyc;
            if (exp_q.size() >= DEPTH) exp_ovf = 1'b1;
            else exp_q.push_back({sof_m, 3'(cur_ch), d});
            sof_m = 1'b0;
          end
        end
        // conversion request
        if (o_cv_go) begin
          cvgo_cnt++;
          if (ch_list.size() == 0) begin
            for (int c = 0; c < 8; c++) if (mask_m[c]) ch_list.push_back(c);
            sof_m = 1'b1;
            if (last_start >= 0) begin
              if (exact_p) check_val("period", 32'(cyc - last_start), cur_p);
              else check_val("period_mod", 32'((cyc - last_start) % cur_p), 0);
            end
            last_start = cyc;
          end
          if (ch_list.size() == 0) begin
            check_val("cv_go_no_mask", o_cv_go, 0);
          end else begin
            cur_ch = ch_list.pop_front();
            check_val("chx", o_chx, cur_ch);
            if (cur_ch == dead_ch) begin
              exp_tmo = 1'b1;
              if (!tmo_chk_done && dead_cyc == 0) dead_cyc = cyc;
            end else begin
              rsp_cnt = lat;
            end
          end
        end
        // timeout boundary around the first abandoned conversion
        if (!tmo_chk_done && dead_cyc > 0) begin
          if (cyc == dead_cyc + TMO - 10) check_val("tmo_early", o_err_tmo, 0);
          if (cyc == dead_cyc + TMO + 10) begin
            check_val("tmo_set", o_err_tmo, 1);
            tmo_chk_done = 1'b1;
          end
        end
      end
    end
  end

  task automatic run_phase(input logic [7:0] mask, input int period, input int l, input int dead,
                           input bit fixed, input int rdy, input bit exact, input int cycles);
    mask_m        = mask;
    i_ch_mask     = mask;
    i_scan_period = PW'(period);
    cur_p         = (period < 2) ? 2 : period;
    lat           = l;
    dead_ch       = dead;
    fixed_data    = fixed;
    rdy_mode      = rdy;
    exact_p       = exact;
    ch_list.delete();
    last_start    = -1;
    exp_ovf       = 1'b0;
    exp_tmo       = 1'b0;
    tmo_chk_done  = 1'b0;
    dead_cyc      = 0;
    cvgo_cnt      = 0;
    late_exp_ph   = late_expected(mask, l, dead, cur_p);
    @(negedge clk);
    i_en = 1'b1;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic end_phase();
    i_en     = 1'b0;
    rdy_mode = 1;
    repeat (1100) @(negedge clk);
    check_val("drain_valid", o_out_valid, 0);
    check_val("drain_model", 32'(exp_q.size()), 0);
    check_val("err_ovf", o_err_ovf, exp_ovf);
    check_val("err_late", o_err_late, late_exp_ph);
    check_val("err_tmo", o_err_tmo, exp_tmo);
    i_clr = 1'b1;
    @(negedge clk);
    i_clr = 1'b0;
    @(negedge clk);
    check_val("clr_flags", {o_err_ovf, o_err_late, o_err_tmo}, 0);
    exp_q.delete();
  endtask

  initial begin
    bit got;
    rst_n = 1'b0; i_en = 1'b0; i_ch_mask = '0; i_scan_period = '0; i_clr = 1'b0;
    i_adc_done = 1'b0; i_adc_data = '0; i_out_ready = 1'b0;
    mask_m = '0; sof_m = 1'b0; lat = 2; dead_ch = 8; rdy_mode = 1; rsp_cnt = 0; cur_ch = 0;
    cur_p = 2; cvgo_cnt = 0; fixed_data = 1'b0; exact_p = 1'b0; tmo_chk_done = 1'b1;
    last_start = -1; dead_cyc = 0; done_cyc = -10; exp_ovf = 0; exp_tmo = 0; late_exp_ph = 0;
    repeat (3) @(negedge clk);
    check_val("rst_cv_go", o_cv_go, 0);
    check_val("rst_chx", o_chx, 0);
    check_val("rst_valid", o_out_valid, 0);
    check_val("rst_data", o_out_data, 0);
    check_val("rst_errs", {o_err_ovf, o_err_late, o_err_tmo}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Two-channel scan with fixed sample: words AA5C then 4A5C every 1000 cycles
    run_phase(8'h14, 1000, 20, 8, 1'b1, 2, 1'b1, 3500);
    end_phase();

    // Empty mask: no conversions, no words, no flags
    run_phase(8'h00, $urandom_range(50, 200), 5, 8, 1'b0, 2, 1'b1, 5000);
    check_val("mask0_cvgo", cvgo_cnt, 0);
    end_phase();

    // Random masks, periods and latencies
    for (int k = 0; k < 3; k++) begin
      run_phase(8'($urandom_range(1, 255)), $urandom_range(300, 600), $urandom_range(3, 20),
                8, 1'b0, 2, 1'b1, 2000);
      end_phase();
    end

    // Period below the minimum clamps to 2; every scan overruns
    run_phase(8'(1 << $urandom_range(0, 7)), 1, 4, 8, 1'b0, 2, 1'b0, 300);
    end_phase();

    // Overflow: consumer stalled, third scan overflows, head word unchanged
    run_phase(8'hFF, 400, 10, 8, 1'b0, 0, 1'b1, 1300);
    i_en = 1'b0;
    repeat (100) @(negedge clk);
    check_val("ovf_set", o_err_ovf, exp_ovf);
    check_val("ovf_valid", o_out_valid, 1);
    check_val("ovf_head", o_out_data, exp_q[0]);
    check_val("ovf_head_tag", o_out_data[15:12], 4'h8);
    i_clr = 1'b1;
    @(negedge clk);
    i_clr = 1'b0;
    exp_ovf = 1'b0;
    @(negedge clk);
    check_val("ovf_clr", o_err_ovf, 0);
    end_phase();

    // Late ticks: 8 slow conversions overrun a 100-cycle period
    run_phase(8'hFF, 100, 40, 8, 1'b0, 2, 1'b0, 1500);
    end_phase();

    // Timeout: channel 3 never answers
    run_phase(8'h0C, 3000, 10, 3, 1'b0, 2, 1'b1, 7000);
    end_phase();

    // Asynchronous reset while waiting for a result
    run_phase(8'hFF, 500, 30, 8, 1'b0, 0, 1'b1, 0);
    got = 1'b0;
    for (int k = 0; k < 2000 && !got; k++) begin
      @(negedge clk);
      if (o_cv_go && o_chx >= 3'd2) got = 1'b1;
    end
    check_val("wait_cvgo", got, 1);
    repeat (5) @(negedge clk);
    check_val("pre_rst_valid", o_out_valid, 1);
    #1;
    rst_n = 1'b0;
    #1;
    check_val("arst_cv_go", o_cv_go, 0);
    check_val("arst_chx", o_chx, 0);
    check_val("arst_valid", o_out_valid, 0);
    check_val("arst_data", o_out_data, 0);
    check_val("arst_errs", {o_err_ovf, o_err_late, o_err_tmo}, 0);
    rsp_cnt = 0;
    exp_q.delete();
    ch_list.delete();
    last_start = -1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    rdy_mode = 2;
    @(negedge clk);
    check_val("post_rst_valid", o_out_valid, 0);
    repeat (1200) @(negedge clk);
    end_phase();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/adc_scan_sequencer.md
Name: adc_scan_sequencer

Overview:
Sits directly upstream and downstream of the adc128s022 serial controller. It paces periodic scans over a run-time channel mask and pulses cv_go/chx for each enabled channel. Each 12-bit result returned with done is captured, tagged with its channel and a start-of-scan marker, and buffered as 16-bit words in a small FIFO with a valid/ready interface toward the USB packet path.

Parameters:
FIFO_DEPTH, 16, output FIFO depth in words; power of two, 4..256
PERIOD_W, 24, width of scan_period
DONE_TIMEOUT, 1024, clk cycles to wait for adc_done before abandoning a channel

Ports:
clk  in  1  system clock
rst_n  in  1  reset
en  in  1  scan enable, level
ch_mask  in  8  bit n=1 enables channel n; sampled at each scan start
scan_period  in  PERIOD_W  clk cycles between scan starts; values <2 treated as 2
clr  in  1  one-cycle pulse, clears err_* flags
cv_go  out  1  conversion request to ADC controller, one-cycle pulse
chx  out  3  channel select to ADC controller
adc_done  in  1  ADC result strobe, one cycle
adc_data  in  12  ADC result, valid with adc_done
out_data  out  16  {sof, ch[2:0], sample[11:0]}
out_valid  out  1  FIFO non-empty, show-ahead
out_ready  in  1  consumer accepts word when out_valid&out_ready
err_ovf  out  1  sticky: word dropped, FIFO full
err_late  out  1  sticky: scan tick arrived while a scan was still in progress
err_tmo  out  1  sticky: adc_done timeout

Behaviour:
- Reset is asynchronous, active-low (rst_n), on a single clock clk. All outputs reset to 0. FIFO is empty, timer is 0, and the FSM is in IDLE.
- Period timer: cleared while en=0. With en=1 it counts 0..P-1 and asserts tick when count=P-1, where P=max(scan_period,2). The first tick occurs P cycles after en rises.
- FSM states: IDLE, WAIT_TICK, SEEK, START, WAIT_DONE.
  - IDLE -> WAIT_TICK when en=1.
  - WAIT_TICK -> SEEK on tick. Latches ch_mask, sets cursor=0 and sof_pend=1.
  - SEEK: finds the lowest enabled channel >= cursor in one cycle. If found, load chx and go to START. If none, go to WAIT_TICK, or to IDLE if en=0. A zero mask therefore produces no cv_go.
  - START: cv_go=1 for exactly this cycle. chx is held stable from START through WAIT_DONE. Go to WAIT_DONE and clear the timeout counter.
  - WAIT_DONE on adc_done: push word {sof_pend, chx, adc_data}, clear sof_pend, set cursor=chx+1, go to SEEK. If cursor wraps past 7, the scan ends.
  - WAIT_DONE on timeout (DONE_TIMEOUT cycles without adc_done): set err_tmo, push nothing, keep sof_pend, advance cursor, go to SEEK.
- en falling mid-scan: the outstanding conversion completes and its word is pushed. No further channels start; the FSM goes to IDLE from SEEK.
- A tick in any state other than WAIT_TICK sets err_late; that tick is discarded.
- FIFO behaviour:
  - First-word fall-through. A push into an empty FIFO gives out_valid=1 on the next cycle, so the word is visible 1 cycle after adc_done.
  - Pop when out_valid&out_ready.
  - Push when full without a same-cycle pop: word dropped, err_ovf set, contents unchanged.
  - Push when full with a same-cycle pop: push accepted.
  - Push and pop on the same cycle otherwise: occupancy unchanged.
- err_* flags are set-dominant over clr in the same cycle.
- adc_done outside WAIT_DONE is ignored.

Decomposition:
- Package adc_scan_pkg holds:
  - word field constants: SOF_BIT=15, CH_MSB=14, CH_LSB=12, DATA_MSB=11
  - FSM state encoding, 3-bit localparams
  - the min-period constant 2
- One sub-module, scan_fifo: synchronous FWFT FIFO, width 16, depth FIFO_DEPTH, with full/empty outputs.

Test Plan:
- ch_mask=8'h14, scan_period=1000, ADC model returns 12'hA5C 20 cycles after cv_go -> one cv_go per channel, chx=2 then 4; words 16'hAA5C then 16'h4A5C; the pattern repeats every 1000 cycles.
- ch_mask=8'h00, en=1 for 5000 cycles -> cv_go never asserts, out_valid stays 0, no err flags.
- ch_mask=8'hFF, out_ready=0, FIFO_DEPTH=16 -> two scans fill 16 words. The first push of the third scan sets err_ovf=1 and out_data still shows the first word (sof=1, ch0). clr clears err_ovf.
- ch_mask=8'hFF, scan_period=100, conversion takes 40 cycles -> err_late=1 and the next scan starts at the following tick after completion.
- ADC model never pulses done on ch3, mask=8'h0C -> after 1024 cycles err_tmo=1, cv_go issued for ch2 next scan as normal; the ch3 word is absent and the ch2 word's sof is set correctly.
- rst_n low during WAIT_DONE -> cv_go, chx, out_valid and err_* are 0 immediately (asynchronous). After release the FIFO is empty and the first word of the next scan has sof=1.
